// File: rtl/bp_reg_initiator.sv
// rtl/bp_reg_initiator.sv - register read/write initiator over a byte-pipe link
module bp_reg_initiator #(
    parameter int N_REG   = 63,
    parameter int TIMEOUT = 1000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cg,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic       i_cmd_wr,
    input  logic [6:0] i_cmd_addr,
    input  logic [7:0] i_cmd_wdata,
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output logic [7:0] o_rsp_rdata,
    output logic       o_rsp_err,
    output logic       o_rsp_timeout,
    output logic [7:0] o_bp_data,
    output logic       o_bp_valid,
    input  logic       i_bp_ready,
    input  logic [7:0] i_bp_data,
    input  logic       i_bp_valid,
    output logic       o_bp_ready
);

    typedef enum logic [2:0] {IDLE, SEND_ADDR, SEND_DATA, WAIT_RSP, RESP} state_t;

    localparam logic [7:0]  NREG_B  = 8'(N_REG);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        bp_valid_q, bp_valid_d;
    logic [7:0]  bp_data_q, bp_data_d;
    logic        bp_ready_q, bp_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        timeout_q, timeout_d;

    // Defaults hold everything, so a low clock gate freezes the whole block.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        bp_valid_d  = bp_valid_q;
        bp_data_d   = bp_data_q;
        bp_ready_d  = bp_ready_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        timeout_d   = timeout_q;
        if (i_cg) begin
            case (state_q)
                IDLE: begin
                    if (i_cmd_valid) begin
                        wr_d    = i_cmd_wr;
                        wdata_d = i_cmd_wdata;
                        if ({1'b0, i_cmd_addr} >= NREG_B) begin
                            state_d     = RESP;
                            rsp_valid_d = 1'b1;
                            rdata_d     = 8'd0;
                            err_d       = 1'b1;
                            timeout_d   = 1'b0;
                        end else begin
                            state_d    = SEND_ADDR;
                            bp_valid_d = 1'b1;
                            bp_data_d  = {i_cmd_wr, i_cmd_addr};
                        end
                    end
                end
                SEND_ADDR: begin
                    if (i_bp_ready) begin
                        if (wr_q) begin
                            state_d   = SEND_DATA;
                            bp_data_d = wdata_q;
                        end else begin
                            state_d    = WAIT_RSP;
                            bp_valid_d = 1'b0;
                            bp_data_d  = 8'd0;
                            bp_ready_d = 1'b1;
                            cnt_d      = 16'd0;
                        end
                    end
                end
                SEND_DATA: begin
                    if (i_bp_ready) begin
                        state_d     = RESP;
                        bp_valid_d  = 1'b0;
                        bp_data_d   = 8'd0;
                        rsp_valid_d = 1'b1;
                        rdata_d     = 8'd0;
                        err_d       = 1'b0;
                        timeout_d   = 1'b0;
                    end
                end
                WAIT_RSP: begin
                    // A byte arriving on the last counted cycle still wins over the timeout.
                    if (i_bp_valid) begin
                        state_d     = RESP;
                        bp_ready_d  = 1'b0;
                        rsp_valid_d = 1'b1;
                        rdata_d     = i_bp_data;
                        err_d       = 1'b0;
                        timeout_d   = 1'b0;
                    end else if (cnt_q == TO_LAST) begin
                        state_d     = RESP;
                        bp_ready_d  = 1'b0;
                        rsp_valid_d = 1'b1;
                        rdata_d     = 8'd0;
                        err_d       = 1'b0;
                        timeout_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        state_d     = IDLE;
                        rsp_valid_d = 1'b0;
                        rdata_d     = 8'd0;
                        err_d       = 1'b0;
                        timeout_d   = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            wr_q        <= 1'b0;
            wdata_q     <= 8'd0;
            bp_valid_q  <= 1'b0;
            bp_data_q   <= 8'd0;
            bp_ready_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 8'd0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            bp_valid_q  <= bp_valid_d;
            bp_data_q   <= bp_data_d;
            bp_ready_q  <= bp_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
        end
    end

    // Ready is masked by reset so it is low throughout reset and high right after.
    assign o_cmd_ready   = (state_q == IDLE) && !i_rst;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rdata_q;
    assign o_rsp_err     = err_q;
    assign o_rsp_timeout = timeout_q;
    assign o_bp_valid    = bp_valid_q;
    assign o_bp_data     = bp_data_q;
    assign o_bp_ready    = bp_ready_q;

endmodule

// File: tb/tb_bp_reg_initiator.sv
// tb/tb_bp_reg_initiator.sv - self-checking bench for bp_reg_initiator
module tb_bp_reg_initiator;

    localparam int NI = 4;
    localparam int NREG_T [NI] = '{2, 5, 63, 127};

    logic clk = 1'b0;
    logic rst;
    logic [NI-1:0] cg, cmd_valid, cmd_wr, cmd_ready, rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [NI-1:0] bp_valid_out, bp_ready_in, bp_valid_in, bp_ready_out;
    logic [6:0] cmd_addr [NI];
    logic [7:0] cmd_wdata [NI];
    logic [7:0] rsp_rdata [NI];
    logic [7:0] bp_data_out [NI];
    logic [7:0] bp_data_in [NI];

    int checks = 0;
    int errors = 0;

    // Golden register image and the responder's own storage, filled only from wire bytes.
    logic [7:0] gold_mem [NI][128];
    logic [7:0] r_mem [NI][128];
    logic [NI-1:0] r_pend, r_want_data;
    logic [7:0] r_data [NI];
    logic [6:0] r_waddr [NI];
    int r_dly [NI];
    bit rand_mode;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bp_reg_initiator #(.N_REG(NREG_T[g]), .TIMEOUT(4)) u_dut (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_cg         (cg[g]),
            .i_cmd_valid  (cmd_valid[g]),
            .o_cmd_ready  (cmd_ready[g]),
            .i_cmd_wr     (cmd_wr[g]),
            .i_cmd_addr   (cmd_addr[g]),
            .i_cmd_wdata  (cmd_wdata[g]),
            .o_rsp_valid  (rsp_valid[g]),
            .i_rsp_ready  (rsp_ready[g]),
            .o_rsp_rdata  (rsp_rdata[g]),
            .o_rsp_err    (rsp_err[g]),
            .o_rsp_timeout(rsp_timeout[g]),
            .o_bp_data    (bp_data_out[g]),
            .o_bp_valid   (bp_valid_out[g]),
            .i_bp_ready   (bp_ready_in[g]),
            .i_bp_data    (bp_data_in[g]),
            .i_bp_valid   (bp_valid_in[g]),
            .o_bp_ready   (bp_ready_out[g])
        );
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic init_mem();
        for (int k = 0; k < NI; k++) begin
            for (int a = 0; a < 128; a++) begin
                gold_mem[k][a] = 8'($urandom);
                r_mem[k][a]    = gold_mem[k][a];
            end
        end
        r_pend      = '0;
        r_want_data = '0;
    endtask

    task automatic resp_drive(input int k);
        bp_ready_in[k] = rand_mode ? ($urandom_range(5) != 0) : 1'b1;
        if (r_pend[k] && r_dly[k] == 0) begin
            bp_valid_in[k] = 1'b1;
            bp_data_in[k]  = r_data[k];
        end else begin
            if (r_pend[k]) r_dly[k]--;
            bp_valid_in[k] = 1'b0;
            bp_data_in[k]  = 8'($urandom);
        end
    endtask

    // Called only when the coming edge is gated in; applies the handshakes it will perform.
    task automatic resp_observe(input int k);
        logic [7:0] b;
        if (bp_valid_out[k] && bp_ready_in[k]) begin
            b = bp_data_out[k];
            if (r_want_data[k]) begin
                r_mem[k][r_waddr[k]] = b;
                r_want_data[k] = 1'b0;
            end else if (b[7]) begin
                r_want_data[k] = 1'b1;
                r_waddr[k]     = b[6:0];
            end else begin
                r_pend[k] = 1'b1;
                r_data[k] = r_mem[k][b[6:0]];
                r_dly[k]  = $urandom_range(2);
            end
        end
        if (bp_ready_out[k] && bp_valid_in[k]) r_pend[k] = 1'b0;
    endtask

    task automatic do_txn(input int k, input logic wr, input logic [6:0] addr, input logic [7:0] wdata);
        logic       e_err;
        logic [7:0] e_rdata;
        bit accepted, done;
        int n;
        e_err   = (int'(addr) >= NREG_T[k]);
        e_rdata = (!e_err && !wr) ? gold_mem[k][addr] : 8'd0;
        if (!e_err && wr) gold_mem[k][addr] = wdata;
        cmd_valid[k] = 1'b1;
        cmd_wr[k]    = wr;
        cmd_addr[k]  = addr;
        cmd_wdata[k] = wdata;
        accepted = 0;
        done     = 0;
        n        = 0;
        while (!done && n < 300) begin
            cg[k]        = rand_mode ? ($urandom_range(99) != 0) : 1'b1;
            rsp_ready[k] = ($urandom_range(3) != 0);
            resp_drive(k);
            if (cg[k]) begin
                if (cmd_valid[k] && cmd_ready[k]) accepted = 1;
                resp_observe(k);
                if (rsp_valid[k] && rsp_ready[k]) begin
                    chk("rsp_after_accept", 16'(accepted), 16'd1);
                    chk("rnd_rdata", rsp_rdata[k], e_rdata);
                    chk("rnd_err", rsp_err[k], e_err);
                    chk("rnd_timeout", rsp_timeout[k], 1'b0);
                    chk("rnd_link_idle", {r_pend[k], r_want_data[k]}, 2'b00);
                    done = 1;
                end
            end
            step();
            n++;
            if (accepted) cmd_valid[k] = 1'b0;
        end
        chk("txn_completed", 16'(done), 16'd1);
        cmd_valid[k]   = 1'b0;
        cg[k]          = 1'b1;
        rsp_ready[k]   = 1'b0;
        bp_valid_in[k] = 1'b0;
    endtask

    task automatic finish_rsp(input int k, input logic [7:0] e_rdata);
        step();
        chk("rsp_hold_valid", rsp_valid[k], 1'b1);
        chk("rsp_hold_rdata", rsp_rdata[k], e_rdata);
        rsp_ready[k] = 1'b1;
        step();
        rsp_ready[k] = 1'b0;
        chk("rsp_released", rsp_valid[k], 1'b0);
        chk("cmd_ready_back", cmd_ready[k], 1'b1);
    endtask

    task automatic man_read(input int k, input logic [6:0] addr, input logic [7:0] data, input int dly);
        cmd_valid[k] = 1'b1; cmd_wr[k] = 1'b0; cmd_addr[k] = addr;
        bp_ready_in[k] = 1'b1; bp_valid_in[k] = 1'b0; rsp_ready[k] = 1'b0;
        step();
        cmd_valid[k] = 1'b0;
        chk("rd_addr_valid", bp_valid_out[k], 1'b1);
        chk("rd_addr_byte", bp_data_out[k], {1'b0, addr});
        step();
        chk("rd_wait_ready", bp_ready_out[k], 1'b1);
        chk("rd_wait_novalid", bp_valid_out[k], 1'b0);
        repeat (dly) step();
        bp_valid_in[k] = 1'b1; bp_data_in[k] = data;
        step();
        bp_valid_in[k] = 1'b0;
        chk("rd_rsp_valid", rsp_valid[k], 1'b1);
        chk("rd_rsp_rdata", rsp_rdata[k], data);
        chk("rd_rsp_err", rsp_err[k], 1'b0);
        chk("rd_rsp_timeout", rsp_timeout[k], 1'b0);
        chk("rd_bp_ready_off", bp_ready_out[k], 1'b0);
        finish_rsp(k, data);
    endtask

    task automatic inv_case(input int k, input logic [6:0] addr);
        cmd_valid[k] = 1'b1; cmd_wr[k] = 1'b0; cmd_addr[k] = addr; bp_ready_in[k] = 1'b1;
        step();
        cmd_valid[k] = 1'b0;
        chk("inv_rsp_valid", rsp_valid[k], 1'b1);
        chk("inv_err", rsp_err[k], 1'b1);
        chk("inv_rdata", rsp_rdata[k], 8'd0);
        chk("inv_no_bp", bp_valid_out[k], 1'b0);
        finish_rsp(k, 8'd0);
    endtask

    task automatic timeout_case(input int k, input bit byte_last, input bit gap);
        cmd_valid[k] = 1'b1; cmd_wr[k] = 1'b0; cmd_addr[k] = 7'd1;
        bp_ready_in[k] = 1'b1; bp_valid_in[k] = 1'b0;
        step();
        cmd_valid[k] = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            if (gap && i == 2) begin
                cg[k] = 1'b0;
                repeat (5) begin
                    step();
                    chk("to_frozen_valid", rsp_valid[k], 1'b0);
                    chk("to_frozen_ready", bp_ready_out[k], 1'b1);
                end
                cg[k] = 1'b1;
            end
            chk("to_waiting", rsp_valid[k], 1'b0);
            if (byte_last && i == 3) begin
                bp_valid_in[k] = 1'b1; bp_data_in[k] = 8'h3C;
            end
            step();
        end
        bp_valid_in[k] = 1'b0;
        chk("to_rsp_valid", rsp_valid[k], 1'b1);
        chk("to_flag", rsp_timeout[k], !byte_last);
        chk("to_rdata", rsp_rdata[k], byte_last ? 8'h3C : 8'h00);
        chk("to_err", rsp_err[k], 1'b0);
        finish_rsp(k, byte_last ? 8'h3C : 8'h00);
    endtask

    initial begin
        int sel;
        logic [6:0] addr;
        rst = 1'b1; cg = '1; cmd_valid = '0; cmd_wr = '0; rsp_ready = '0;
        bp_ready_in = '0; bp_valid_in = '0; rand_mode = 0;
        for (int k = 0; k < NI; k++) begin
            cmd_addr[k] = '0; cmd_wdata[k] = '0; bp_data_in[k] = '0;
            r_data[k] = '0; r_waddr[k] = '0; r_dly[k] = 0;
        end
        init_mem();
        step(); step();
        for (int k = 0; k < NI; k++) begin
            chk("rst_cmd_ready", cmd_ready[k], 1'b0);
            chk("rst_bp_valid", bp_valid_out[k], 1'b0);
            chk("rst_bp_data", bp_data_out[k], 8'd0);
            chk("rst_bp_ready", bp_ready_out[k], 1'b0);
            chk("rst_rsp", {rsp_valid[k], rsp_err[k], rsp_timeout[k], rsp_rdata[k]}, 11'd0);
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) chk("post_rst_cmd_ready", cmd_ready[k], 1'b1);

        man_read(2, 7'h05, 8'h57, 1);

        cmd_valid[2] = 1'b1; cmd_wr[2] = 1'b1; cmd_addr[2] = 7'h10; cmd_wdata[2] = 8'hA5;
        bp_ready_in[2] = 1'b0;
        step();
        cmd_valid[2] = 1'b0; cmd_wdata[2] = 8'h00;
        repeat (3) begin
            chk("wr_addr_hold_valid", bp_valid_out[2], 1'b1);
            chk("wr_addr_hold_byte", bp_data_out[2], 8'h90);
            step();
        end
        bp_ready_in[2] = 1'b1;
        step();
        bp_ready_in[2] = 1'b0;
        repeat (3) begin
            chk("wr_data_hold_valid", bp_valid_out[2], 1'b1);
            chk("wr_data_hold_byte", bp_data_out[2], 8'hA5);
            step();
        end
        bp_ready_in[2] = 1'b1;
        step();
        chk("wr_rsp_valid", rsp_valid[2], 1'b1);
        chk("wr_rsp_fields", {rsp_err[2], rsp_timeout[2], rsp_rdata[2]}, 10'd0);
        chk("wr_bp_idle", bp_valid_out[2], 1'b0);
        finish_rsp(2, 8'd0);

        inv_case(1, 7'h05);
        inv_case(3, 7'h7F);
        cmd_valid[1] = 1'b1; cmd_wr[1] = 1'b1; cmd_addr[1] = 7'h04; cmd_wdata[1] = 8'h22;
        bp_ready_in[1] = 1'b1;
        step();
        cmd_valid[1] = 1'b0;
        chk("last_addr_sent", bp_valid_out[1], 1'b1);
        chk("last_addr_byte", bp_data_out[1], 8'h84);
        step(); step();
        chk("last_addr_rsp", {rsp_valid[1], rsp_err[1]}, 2'b10);
        finish_rsp(1, 8'd0);

        timeout_case(2, 0, 0);
        timeout_case(2, 1, 0);
        timeout_case(2, 0, 1);

        cmd_valid[2] = 1'b1; cmd_wr[2] = 1'b1; cmd_addr[2] = 7'h03; cmd_wdata[2] = 8'h11;
        bp_ready_in[2] = 1'b1; bp_valid_in[2] = 1'b0;
        step();
        cmd_valid[2] = 1'b0;
        step();
        bp_ready_in[2] = 1'b0;
        chk("sd_valid", bp_valid_out[2], 1'b1);
        chk("sd_byte", bp_data_out[2], 8'h11);
        rst = 1'b1; cg = '0;
        #1;
        chk("rst_mid_cmd_ready", cmd_ready[2], 1'b0);
        step();
        chk("rst_mid_bp_valid", bp_valid_out[2], 1'b0);
        chk("rst_mid_bp_data", bp_data_out[2], 8'd0);
        rst = 1'b0; cg = '1;
        #1;
        chk("rst_mid_cmd_ready_back", cmd_ready[2], 1'b1);
        man_read(2, 7'h03, 8'h66, 0);

        init_mem();
        bp_valid_in = '0;
        rand_mode = 1;
        for (int k = 0; k < NI; k++) begin
            repeat (150) begin
                sel = $urandom_range(7);
                if (sel == 0)      addr = 7'(NREG_T[k] - 1);
                else if (sel == 1) addr = 7'(NREG_T[k]);
                else if (sel == 2) addr = 7'h7F;
                else               addr = 7'($urandom_range(NREG_T[k] - 1));
                do_txn(k, 1'($urandom_range(1)), addr, 8'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_reg_initiator.md
BP_REG_INITIATOR -- requirements
Module: bp_reg_initiator

Interface
REQ-001 Parameter N_REG, default 63, range 2..127: number of registers at the responder; addresses >= N_REG are invalid.
REQ-002 Parameter TIMEOUT, default 1000, range 1..65535: cycles to wait for a read response byte.
REQ-003 i_clk  input  1  sole clock; all state updates on posedge i_clk.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_cg  input  1  clock gate; when 0, all state and outputs hold.
REQ-006 i_cmd_valid  input  1  command request.
REQ-007 o_cmd_ready  output  1  command accepted when i_cmd_valid & o_cmd_ready & i_cg.
REQ-008 i_cmd_wr  input  1  1 = write, 0 = read.
REQ-009 i_cmd_addr  input  7  register address.
REQ-010 i_cmd_wdata  input  8  write data.
REQ-011 o_rsp_valid  output  1  response available.
REQ-012 i_rsp_ready  input  1  response consumed when o_rsp_valid & i_rsp_ready & i_cg.
REQ-013 o_rsp_rdata  output  8  read data; 0 for writes and errors.
REQ-014 o_rsp_err  output  1  address was invalid; no bus traffic occurred.
REQ-015 o_rsp_timeout  output  1  no read response byte arrived within TIMEOUT cycles.
REQ-016 o_bp_data, o_bp_valid, i_bp_ready  output/output/input  8/1/1  byte-pipe toward responder.
REQ-017 i_bp_data, i_bp_valid, o_bp_ready  input/input/output  8/1/1  byte-pipe from responder.

Function
REQ-018 Wire format is fixed. Read sends one byte {1'b0, addr} and receives one data byte. Write sends {1'b1, addr} then wdata and receives nothing.
REQ-019 The FSM states are IDLE, SEND_ADDR, SEND_DATA, WAIT_RSP and RESP. All outputs are registered or decoded from state.
REQ-020 IDLE: o_cmd_ready=1, and it is 0 in every other state. One command is in flight at a time.
REQ-021 Accept in IDLE: cmd fields are latched. If addr >= N_REG, go to RESP with err=1. Otherwise go to SEND_ADDR.
REQ-022 SEND_ADDR: o_bp_valid=1 and o_bp_data={wr,addr}, held stable until i_bp_ready. On handshake, go to SEND_DATA if wr, else to WAIT_RSP.
REQ-023 SEND_DATA: o_bp_valid=1 and o_bp_data=wdata, held until i_bp_ready. On handshake, go to RESP with err=0, timeout=0, rdata=0.
REQ-024 WAIT_RSP: o_bp_ready=1, and the 16-bit wait counter starts at 0 on entry. Each gated cycle without i_bp_valid increments it. On i_bp_valid, latch i_bp_data to rdata and go to RESP.
REQ-025 Timeout: if the counter reaches TIMEOUT-1 without i_bp_valid, go to RESP with timeout=1 and rdata=0. If i_bp_valid arrives on that same cycle, the data wins and timeout=0.
REQ-026 o_bp_ready=0 outside WAIT_RSP; stray bytes are not consumed.
REQ-027 o_bp_valid=0 outside SEND_ADDR and SEND_DATA.
REQ-028 RESP: o_rsp_valid=1, with rdata, err and timeout stable, until i_rsp_ready, then go to IDLE. The next command is accepted no earlier than the following cycle.
REQ-029 Minimum latency, accept to o_rsp_valid, with ready partners: read is 3 cycles; write is 3 cycles; invalid address is 1 cycle.
REQ-030 i_cg=0 freezes the FSM, counter and outputs. Handshakes are only counted when i_cg=1.

Reset
REQ-031 Reset takes priority over i_cg and over all events, and acts mid-transaction by abandoning it.
REQ-032 Reset values: state=IDLE, counter=0, o_bp_valid=0, o_bp_data=0, o_bp_ready=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_rsp_timeout=0. o_cmd_ready is 0 during reset and 1 on the first cycle after reset.

Verification
REQ-033 Read of addr 0x05 with the responder returning 0x57 after 2 cycles -> bp out 0x05; o_rsp_valid with rdata=0x57, err=0, timeout=0.
REQ-034 Write addr 0x10, data 0xA5, with i_bp_ready low for 3 cycles -> bytes 0x90 then 0xA5 held stable; response with rdata=0, err=0.
REQ-035 N_REG=5, read addr 0x05 -> no o_bp_valid; response err=1 after 1 cycle.
REQ-036 TIMEOUT=4, no responder byte -> response timeout=1 exactly 4 cycles after entering WAIT_RSP. A byte on the 4th cycle -> data returned, timeout=0.
REQ-037 Assert i_rst while in SEND_DATA -> o_bp_valid=0 next cycle, then IDLE. A subsequent read completes normally.
REQ-038 Random i_cg drops (1/100) and i_bp_ready drops (1/6) against the responder with N_REG 2, 5, 63 and 127 -> all reads return the last value written; no handshake is lost or duplicated.
